imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter SHORT_W, default 16, giving the immediate input width.
REQ-002 The block SHALL have parameter EXT_W, default 32, giving the extended output width; legal only when EXT_W > SHORT_W + 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discards all buffered entries (pipeline squash).
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream offers an immediate.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-009 The block SHALL have port in_imm, input, SHORT_W bits: the raw immediate field.
REQ-010 The block SHALL have port in_mode, input, 2 bits: 0=SEXT, 1=ZEXT, 2=UPPER, 3=BRANCH.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_imm holds a valid result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream accepts this cycle.
REQ-013 The block SHALL have port out_imm, output, EXT_W bits: the extended result.
REQ-014 The block SHALL have port out_neg, output, 1 bit: the MSB of out_imm.

Function
REQ-015 Transfer SHALL occur on in_valid&&in_ready (push) and on out_valid&&out_ready (pop).
REQ-016 Mode SEXT SHALL produce in_imm[SHORT_W-1] replicated into bits [EXT_W-1:SHORT_W], for any parameter values (no fixed-width fill constants).
REQ-017 Mode ZEXT SHALL zero the upper EXT_W-SHORT_W bits.
REQ-018 Mode UPPER SHALL place in_imm in bits [EXT_W-1:EXT_W-SHORT_W] and zero all lower bits.
REQ-019 Mode BRANCH SHALL produce SEXT(in_imm) shifted left 2, truncated to EXT_W bits.
REQ-020 The result SHALL be computed at push time and stored in a 2-entry FIFO (skid buffer), with occupancy states EMPTY, ONE and FULL.
REQ-021 Transitions SHALL be: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; every other case holds state.
REQ-022 in_ready SHALL equal (state!=FULL)&&!reset, a function of registered state only, with no combinational path from out_ready.
REQ-023 out_valid SHALL equal (state!=EMPTY); out_imm and out_neg SHALL show the oldest entry and SHALL be 0 when EMPTY.
REQ-024 Latency SHALL be 1 cycle: a push at edge N gives out_valid=1 with the result after edge N.
REQ-025 Throughput SHALL be 1 per cycle when out_ready is held at 1.
REQ-026 Order SHALL be strictly FIFO, with no loss or duplication.
REQ-027 A stalled output (out_valid=1, out_ready=0) SHALL hold out_imm and out_neg stable until popped.
REQ-028 When full, a push is impossible, and a simultaneous pop frees one slot that is visible as in_ready=1 in the next cycle.
REQ-029 Flush SHALL take effect at the next edge: state->EMPTY and stored data->0; any push or pop in the same cycle is discarded.
REQ-030 Flush has priority over push and pop, and reset has priority over flush.

Reset
REQ-031 While reset=1 the block SHALL hold in_ready=0 and ignore in_valid, out_ready and flush.
REQ-032 After the reset edge the block SHALL be in state EMPTY, with out_valid=0, out_imm=0 and out_neg=0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-034 A reset arriving mid-stream SHALL drop all entries, including a stalled one.

Verification
REQ-035 Mode sweep, defaults, out_ready=1: in_imm=16'h8001 in modes 0/1/2/3 SHALL give out_imm=32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004 in order, each one cycle after its push.
REQ-036 Parameter check, SHORT_W=12, EXT_W=24: SEXT of 12'h800 SHALL give 24'hFFF800 and ZEXT of 12'hFFF SHALL give 24'h000FFF.
REQ-037 Backpressure: three pushes (1,2,3) with out_ready=0 SHALL accept only 1 and 2, then show in_ready=0; raising out_ready SHALL yield 1, 2, then 3 with none lost.
REQ-038 Simultaneous push and pop in state ONE SHALL keep state ONE, output the older value, and leave the new value next.
REQ-039 Flush while FULL with a concurrent push SHALL give out_valid=0 next cycle, and the pushed value SHALL never appear.
REQ-040 Reset asserted for 1 cycle while FULL and stalled SHALL give out_valid=0 and out_imm=0 after the edge, and in_ready=1 the following cycle.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream immediate offer plus downstream result.
// The slave modport is the block's view; the master modport is the surrounding logic's view.
interface imm_extend_pipe_if #(
    parameter int unsigned SHORT_W = 16,
    parameter int unsigned EXT_W   = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [SHORT_W-1:0] in_imm;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [EXT_W-1:0]   out_imm;
    logic               out_neg;

    modport master (
        output in_valid,
        output in_imm,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_neg
    );

    modport slave (
        input  in_valid,
        input  in_imm,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_neg
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry skid FIFO on its output.
// The extended value is computed when an immediate is accepted; the FIFO decouples
// in_ready from out_ready so the upstream never sees a combinational path from downstream.
module imm_extend_pipe #(
    parameter int unsigned SHORT_W = 16,
    parameter int unsigned EXT_W   = 32
) (
    input logic               clk,
    input logic               reset,
    input logic               flush,
    imm_extend_pipe_if.slave  bus
);

    localparam int unsigned FillW = EXT_W - SHORT_W;

    // The BRANCH shift needs two spare bits above the sign-extended field.
    if (EXT_W <= SHORT_W + 2) begin : g_bad_params
        $error("imm_extend_pipe: EXT_W must exceed SHORT_W + 2");
    end

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e             state_q, state_d;
    // head holds the oldest entry, tail the second one (valid only in StFull).
    logic [EXT_W-1:0]   head_q, head_d;
    logic [EXT_W-1:0]   tail_q, tail_d;
    logic [EXT_W-1:0]   sext_val;
    logic [EXT_W-1:0]   ext_res;
    logic [EXT_W-1:0]   out_imm;
    logic               in_ready;
    logic               out_valid;
    logic               push;
    logic               pop;

    assign in_ready  = (state_q != StFull) && !reset;
    assign out_valid = (state_q != StEmpty);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Extend the incoming immediate according to its mode.
    always_comb begin
        sext_val = {{FillW{bus.in_imm[SHORT_W-1]}}, bus.in_imm};
        ext_res  = '0;
        case (bus.in_mode)
            2'd0:    ext_res = sext_val;
            2'd1:    ext_res = {{FillW{1'b0}}, bus.in_imm};
            2'd2:    ext_res = {bus.in_imm, {FillW{1'b0}}};
            2'd3:    ext_res = {sext_val[EXT_W-3:0], 2'b00};
            default: ext_res = '0;
        endcase
    end

    // Occupancy FSM and slot updates; flush empties and clears both slots.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = StEmpty;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        head_d  = ext_res;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_d = ext_res;
                    end else if (push) begin
                        state_d = StFull;
                        tail_d  = ext_res;
                    end else if (pop) begin
                        state_d = StEmpty;
                        head_d  = '0;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d = StOne;
                        head_d  = tail_q;
                        tail_d  = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    // State register; reset outranks flush and any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_imm       = out_valid ? head_q : '0;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_imm   = out_imm;
    assign bus.out_neg   = out_imm[EXT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_imm_extend_pipe;

    localparam int SW  = 16;
    localparam int EW  = 32;
    localparam int SW2 = 12;
    localparam int EW2 = 24;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.SHORT_W(SW), .EXT_W(EW)) bus ();
    imm_extend_pipe_if #(.SHORT_W(SW2), .EXT_W(EW2)) bus2 ();

    imm_extend_pipe #(.SHORT_W(SW), .EXT_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    imm_extend_pipe #(.SHORT_W(SW2), .EXT_W(EW2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .flush (flush2),
        .bus   (bus2.slave)
    );

    // Reference extension from arithmetic: signed value, scaling, then modulo 2^ew.
    function automatic logic [63:0] ref_ext(int sw, int ew, longint imm, int mode);
        longint s, r, mask;
        s = imm;
        if (imm >= (64'sd1 <<< (sw - 1))) s = imm - (64'sd1 <<< sw);
        case (mode)
            0:       r = s;
            1:       r = imm;
            2:       r = imm * (64'sd1 <<< (ew - sw));
            default: r = s * 4;
        endcase
        mask = (64'sd1 <<< ew) - 1;
        return 64'(r & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h1234;
        bus.in_mode  = 2'd0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.out_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b imm=%h neg=%b exp 0/0/0",
                     bus.out_valid, bus.out_imm, bus.out_neg);
        end
        reset        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b/%b exp 1/1", bus.in_ready, bus2.in_ready);
        end
    endtask

    task automatic test_mode_sweep();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'hFFFF8001;
        exp_v[1] = 32'h00008001;
        exp_v[2] = 32'h80010000;
        exp_v[3] = 32'hFFFE0004;
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'h8001;
            bus.in_mode  = 2'(m);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_imm !== exp_v[m]
                || bus.out_neg !== exp_v[m][31]) begin
                errors++;
                $display("FAIL mode_sweep_%0d got v=%b imm=%h neg=%b exp 1/%h/%b",
                         m, bus.out_valid, bus.out_imm, bus.out_neg, exp_v[m], exp_v[m][31]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0) begin
            errors++;
            $display("FAIL mode_sweep_drain got v=%b imm=%h exp 0/0", bus.out_valid, bus.out_imm);
        end
    endtask

    task automatic test_params();
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.in_imm    = 12'h800;
        bus2.in_mode   = 2'd0;
        tick();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_imm !== 24'hFFF800 || bus2.out_neg !== 1'b1) begin
            errors++;
            $display("FAIL param_sext got v=%b imm=%h exp 1/fff800", bus2.out_valid, bus2.out_imm);
        end
        bus2.in_imm  = 12'hFFF;
        bus2.in_mode = 2'd1;
        tick();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_imm !== 24'h000FFF || bus2.out_neg !== 1'b0) begin
            errors++;
            $display("FAIL param_zext got v=%b imm=%h exp 1/000fff", bus2.out_valid, bus2.out_imm);
        end
        bus2.in_valid = 1'b0;
        tick();
        checks++;
        if (bus2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL param_drain got v=%b exp 0", bus2.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'd1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'd1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_imm !== 32'd1) begin
            errors++;
            $display("FAIL bp_first got rdy=%b imm=%h exp 1/1", bus.in_ready, bus.out_imm);
        end
        bus.in_imm = 16'd2;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_imm !== 32'd1) begin
            errors++;
            $display("FAIL bp_full got rdy=%b imm=%h exp 0/1", bus.in_ready, bus.out_imm);
        end
        bus.in_imm = 16'd3;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_imm !== 32'd1) begin
            errors++;
            $display("FAIL bp_stall got rdy=%b v=%b imm=%h exp 0/1/1",
                     bus.in_ready, bus.out_valid, bus.out_imm);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_imm !== 32'd2 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1 got imm=%h rdy=%b exp 2/1", bus.out_imm, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'd3) begin
            errors++;
            $display("FAIL bp_third got v=%b imm=%h exp 1/3", bus.out_valid, bus.out_imm);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_push_pop_one();
        logic [15:0] a;
        logic [15:0] b;
        logic [63:0] ea;
        logic [63:0] eb;
        a  = 16'($urandom);
        b  = 16'($urandom);
        ea = ref_ext(SW, EW, longint'(a), 0);
        eb = ref_ext(SW, EW, longint'(b), 0);
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'd0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = a;
        tick();
        checks++;
        if (bus.out_imm !== ea[31:0]) begin
            errors++;
            $display("FAIL pp_older got %h exp %h", bus.out_imm, ea[31:0]);
        end
        bus.in_imm    = b;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== eb[31:0] || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_newer got v=%b imm=%h rdy=%b exp 1/%h/1",
                     bus.out_valid, bus.out_imm, bus.in_ready, eb[31:0]);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pp_single_entry got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'd1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0011;
        tick();
        bus.in_imm = 16'h0022;
        tick();
        flush         = 1'b1;
        bus.in_imm    = 16'h0033;
        bus.out_ready = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty got v=%b imm=%h rdy=%b exp 0/0/1",
                     bus.out_valid, bus.out_imm, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_ghost got v=%b imm=%h exp 0", bus.out_valid, bus.out_imm);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'd2;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'hA5A5;
        tick();
        bus.in_imm = 16'h5A5A;
        tick();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready got %b exp 0", bus.in_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.out_neg !== 1'b0
            || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state got v=%b imm=%h neg=%b rdy=%b exp 0/0/0/1",
                     bus.out_valid, bus.out_imm, bus.out_neg, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dropped got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] q [$];
        logic [63:0]   e;
        logic          push;
        logic          pop;
        int            mism;
        mism = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2)
                || (q.size() > 0 && (bus.out_imm !== q[0] || bus.out_neg !== q[0][EW-1]))
                || (q.size() == 0 && bus.out_imm !== '0)) begin
                errors++;
                if (mism < 10)
                    $display("FAIL random_cyc%0d got v=%b rdy=%b imm=%h exp v=%b rdy=%b imm=%h",
                             cyc, bus.out_valid, bus.in_ready, bus.out_imm, q.size() > 0,
                             q.size() < 2, (q.size() > 0) ? q[0] : '0);
                mism++;
            end
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_imm    = 16'($urandom);
            bus.in_mode   = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            push = bus.in_valid && (q.size() < 2);
            pop  = bus.out_ready && (q.size() > 0);
            e    = ref_ext(SW, EW, longint'(bus.in_imm), int'(bus.in_mode));
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e[EW-1:0]);
            end
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        flush          = 1'b0;
        flush2         = 1'b0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_imm     = '0;
        bus.in_mode    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_imm    = '0;
        bus2.in_mode   = '0;
        bus2.out_ready = 1'b0;
        test_reset();
        test_mode_sweep();
        test_params();
        test_backpressure();
        test_push_pop_one();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
